sce_recompose: RTL and testbench

- Inverse of the sequence decomposer. Takes zero, positive and negative sequence sample streams and reconstructs the three-phase samples Va, Vb, Vc.
- The ±120°/240° phase rotations use a two-tap, current-plus-previous-sample approximation.
- Sits downstream of the decomposer. Used for round-trip checking and for injecting synthetic unbalanced three-phase stimulus into the datapath.

---
 rtl/sce_recompose.sv | 144 ++++++++++++++
 tb/tb_sce_recompose.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sce_recompose.sv
// Sequence-to-phase recomposer: rebuilds Va/Vb/Vc from zero/positive/negative streams
// with two-tap rotations. Define SCE_RECOMP_SATCNT_EN to add the sat_cnt clip counter.
module sce_recompose #(
  parameter int                 M         = 14,
  parameter int                 Q         = 12,
  parameter logic signed [15:0] LAG120_C0 = -16'sd4096,
  parameter logic signed [15:0] LAG120_C1 = 16'sd4096,
  parameter logic signed [15:0] LAG240_C0 = 16'sd0,
  parameter logic signed [15:0] LAG240_C1 = -16'sd4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                hist_clr,
  input  logic signed [M-1:0] Vzero,
  input  logic signed [M-1:0] Vpos,
  input  logic signed [M-1:0] Vneg,
  output logic signed [M-1:0] Va,
  output logic signed [M-1:0] Vb,
  output logic signed [M-1:0] Vc,
  output logic                out_valid,
  output logic                sat_flag
`ifdef SCE_RECOMP_SATCNT_EN
  ,
  output logic [15:0]         sat_cnt
`endif
);
  localparam int RW = M + 17;
  localparam int SW = M + 19;
  localparam logic signed [SW-1:0] SMAX = SW'((1 <<< (M - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

  typedef enum logic {EMPTY, RUN} state_e;

  state_e              state_q;
  logic signed [M-1:0] vp1_q, vn1_q;
  logic signed [M-1:0] z_q, p_q, n_q;
  logic signed [RW-1:0] p120_q, p240_q, n120_q, n240_q;
  logic signed [RW-1:0] p120_d, p240_d, n120_d, n240_d;
  logic signed [M-1:0] va_q, vb_q, vc_q;
  logic                sat_q;
  logic [1:0]          vld_pipe_q;
  logic signed [SW-1:0] sum_a, sum_b, sum_c;
  logic                clip_any;
  logic                accept_run;

  function automatic logic signed [RW-1:0] rot(input logic signed [15:0] c0,
                                               input logic signed [15:0] c1,
                                               input logic signed [M-1:0] s,
                                               input logic signed [M-1:0] s1);
    logic signed [RW-1:0] acc;
    acc = RW'(c0) * RW'(s) + RW'(c1) * RW'(s1);
    return acc >>> Q;
  endfunction

  function automatic logic ovf(input logic signed [SW-1:0] s);
    return (s > SMAX) || (s < SMIN);
  endfunction

  function automatic logic signed [M-1:0] clip(input logic signed [SW-1:0] s);
    if (s > SMAX)      return M'(SMAX);
    else if (s < SMIN) return M'(SMIN);
    else               return s[M-1:0];
  endfunction

  assign p120_d = rot(LAG120_C0, LAG120_C1, Vpos, vp1_q);
  assign p240_d = rot(LAG240_C0, LAG240_C1, Vpos, vp1_q);
  assign n120_d = rot(LAG120_C0, LAG120_C1, Vneg, vn1_q);
  assign n240_d = rot(LAG240_C0, LAG240_C1, Vneg, vn1_q);

  // A cleared or empty history turns the sample into history only.
  assign accept_run = in_valid && !hist_clr && (state_q == RUN);

  always_comb begin
    sum_a    = SW'(z_q) + SW'(p_q) + SW'(n_q);
    sum_b    = SW'(z_q) + SW'(p120_q) + SW'(n240_q);
    sum_c    = SW'(z_q) + SW'(p240_q) + SW'(n120_q);
    clip_any = ovf(sum_a) || ovf(sum_b) || ovf(sum_c);
  end

`ifdef SCE_RECOMP_SATCNT_EN
  logic [15:0] sat_cnt_q;
  assign sat_cnt = sat_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      vp1_q      <= '0;
      vn1_q      <= '0;
      z_q        <= '0;
      p_q        <= '0;
      n_q        <= '0;
      p120_q     <= '0;
      p240_q     <= '0;
      n120_q     <= '0;
      n240_q     <= '0;
      va_q       <= '0;
      vb_q       <= '0;
      vc_q       <= '0;
      sat_q      <= 1'b0;
      vld_pipe_q <= '0;
`ifdef SCE_RECOMP_SATCNT_EN
      sat_cnt_q  <= '0;
`endif
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], accept_run};
      if (accept_run) begin
        z_q    <= Vzero;
        p_q    <= Vpos;
        n_q    <= Vneg;
        p120_q <= p120_d;
        p240_q <= p240_d;
        n120_q <= n120_d;
        n240_q <= n240_d;
      end
      if (in_valid) begin
        vp1_q   <= Vpos;
        vn1_q   <= Vneg;
        state_q <= RUN;
      end else if (hist_clr) begin
        vp1_q   <= '0;
        vn1_q   <= '0;
        state_q <= EMPTY;
      end
      // Stage 2 runs for any stage-1 result, even across a history clear.
      if (vld_pipe_q[0]) begin
        va_q <= clip(sum_a);
        vb_q <= clip(sum_b);
        vc_q <= clip(sum_c);
        if (clip_any) sat_q <= 1'b1;
`ifdef SCE_RECOMP_SATCNT_EN
        if (clip_any && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
`endif
      end
    end
  end

  assign Va        = va_q;
  assign Vb        = vb_q;
  assign Vc        = vc_q;
  assign out_valid = vld_pipe_q[1];
  assign sat_flag  = sat_q;
endmodule

// File: tb/tb_sce_recompose.sv
// Self-checking bench for sce_recompose: directed scenarios plus randomized traffic
// scored against an arithmetic model of the phase reconstruction.
module tb_sce_recompose;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               hist_clr = 1'b0;
  logic signed [13:0] Vzero = '0, Vpos = '0, Vneg = '0;
  logic signed [13:0] Va, Vb, Vc;
  logic               out_valid, sat_flag;
`ifdef SCE_RECOMP_SATCNT_EN
  logic [15:0]        sat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit  m_run;
  int  m_hp, m_hn;
  bit  m_pv, m_pclip;
  int  m_pa, m_pb, m_pc;
  bit  e_ov, e_sat;
  int  e_a, e_b, e_c, e_cnt;

  sce_recompose dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .hist_clr(hist_clr),
    .Vzero(Vzero), .Vpos(Vpos), .Vneg(Vneg),
    .Va(Va), .Vb(Vb), .Vc(Vc), .out_valid(out_valid), .sat_flag(sat_flag)
`ifdef SCE_RECOMP_SATCNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // 120 deg lag: -s + s1 ; 240 deg lag: -s1 (Q12 coefficients, floor shift)
  function automatic longint rot120(longint s, longint s1);
    return (-64'sd4096 * s + 64'sd4096 * s1) >>> 12;
  endfunction
  function automatic longint rot240(longint s, longint s1);
    return (64'sd0 * s - 64'sd4096 * s1) >>> 12;
  endfunction
  function automatic int clampv(longint v);
    if (v > 8191)  return 8191;
    if (v < -8192) return -8192;
    return int'(v);
  endfunction

  task automatic model_reset();
    m_run = 0; m_hp = 0; m_hn = 0; m_pv = 0; m_pclip = 0;
    m_pa = 0; m_pb = 0; m_pc = 0;
    e_ov = 0; e_sat = 0; e_a = 0; e_b = 0; e_c = 0; e_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and return after the edge.
  task automatic cycle(input bit iv, input bit hc, input int z, input int p, input int n);
    longint a, b, c;
    @(negedge clk);
    in_valid = iv; hist_clr = hc;
    Vzero = 14'(z); Vpos = 14'(p); Vneg = 14'(n);
    e_ov = m_pv;
    if (m_pv) begin
      e_a = m_pa; e_b = m_pb; e_c = m_pc;
      if (m_pclip) begin
        e_sat = 1;
        if (e_cnt < 65535) e_cnt++;
      end
    end
    m_pv = 0;
    if (iv && !hc && m_run) begin
      a = longint'(z) + p + n;
      b = longint'(z) + rot120(p, m_hp) + rot240(n, m_hn);
      c = longint'(z) + rot240(p, m_hp) + rot120(n, m_hn);
      m_pa = clampv(a); m_pb = clampv(b); m_pc = clampv(c);
      m_pclip = (m_pa != a) || (m_pb != b) || (m_pc != c);
      m_pv = 1;
    end
    if (iv) begin
      m_hp = p; m_hn = n; m_run = 1;
    end else if (hc) begin
      m_hp = 0; m_hn = 0; m_run = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 0; in_valid = 0; hist_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, sat_flag, Va, Vb, Vc} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%0b sat=%0b Va=%0d Vb=%0d Vc=%0d expected all 0",
               out_valid, sat_flag, Va, Vb, Vc);
    end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0);
      n_tests++;
      if ({out_valid, sat_flag, Va, Vb, Vc} !== 44'd0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got ov=%0b sat=%0b Va=%0d expected 0", i, out_valid, sat_flag, Va);
      end
    end
  endtask

  // Directed two-sample scenario: history load, run sample, then the pulse and a hold cycle.
  task automatic test_seq(input string nm, input int z0, p0, n0, z1, p1, n1,
                          input int xa, xb, xc);
    cycle(1, 1, z0, p0, n0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_first_no_out: got ov=%0b expected 0", nm, out_valid); end
    cycle(1, 0, z1, p1, n1);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_latency: got ov=%0b expected 0", nm, out_valid); end
    cycle(0, 0, 0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1 || int'(Va) != xa || int'(Vb) != xb || int'(Vc) != xc) begin
      n_fail++;
      $display("FAIL %s_out: got ov=%0b Va=%0d Vb=%0d Vc=%0d expected ov=1 %0d %0d %0d",
               nm, out_valid, Va, Vb, Vc, xa, xb, xc);
    end
    cycle(0, 0, 0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b0 || int'(Va) != xa || int'(Vb) != xb || int'(Vc) != xc) begin
      n_fail++;
      $display("FAIL %s_hold: got ov=%0b Va=%0d Vb=%0d Vc=%0d expected ov=0 %0d %0d %0d",
               nm, out_valid, Va, Vb, Vc, xa, xb, xc);
    end
  endtask

  task automatic test_saturation();
    n_tests++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_pre: got %0b expected 0", sat_flag); end
    test_seq("sat", 8000, 8000, 0, 8000, 8000, 0, 8191, 8000, 0);
    n_tests++;
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %0b expected 1", sat_flag); end
`ifdef SCE_RECOMP_SATCNT_EN
    n_tests++;
    if (sat_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 1", sat_cnt); end
`endif
    repeat (3) cycle(1, 0, 10, 20, 30);
    repeat (2) cycle(0, 0, 0, 0, 0);
    n_tests++;
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %0b expected 1", sat_flag); end
  endtask

  task automatic test_hist_clr();
    int z, p, n;
    cycle(1, 1, 5, 7, 9);
    for (int i = 0; i < 5; i++) begin
      z = $urandom_range(0, 400) - 200; p = $urandom_range(0, 400) - 200; n = $urandom_range(0, 400) - 200;
      // i==4 is the cleared-cycle sample: history only, no output of its own
      cycle(1, (i == 4), z, p, n);
    end
    cycle(1, 0, 33, -44, 55);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_no_out: got ov=%0b expected 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 11 * i, -3 * i, 17 - i);
      n_tests++;
      if (out_valid !== 1'b1 || int'(Va) != e_a || int'(Vb) != e_b || int'(Vc) != e_c) begin
        n_fail++;
        $display("FAIL clr_resume[%0d]: got ov=%0b Va=%0d Vb=%0d Vc=%0d expected ov=1 %0d %0d %0d",
                 i, out_valid, Va, Vb, Vc, e_a, e_b, e_c);
      end
    end
  endtask

  task automatic test_random();
    bit iv, hc;
    int z, p, n, lim;
    for (int i = 0; i < 400; i++) begin
      iv  = ($urandom_range(0, 3) != 0);
      hc  = ($urandom_range(0, 9) == 0);
      lim = (i < 200) ? 2000 : 8191;
      z = int'($urandom_range(0, 2 * lim)) - lim;
      p = int'($urandom_range(0, 2 * lim)) - lim;
      n = int'($urandom_range(0, 2 * lim)) - lim;
      cycle(iv, hc, z, p, n);
      n_tests++;
      if (out_valid !== e_ov || sat_flag !== e_sat || int'(Va) != e_a || int'(Vb) != e_b || int'(Vc) != e_c) begin
        n_fail++;
        $display("FAIL random[%0d]: got ov=%0b sat=%0b Va=%0d Vb=%0d Vc=%0d expected ov=%0b sat=%0b %0d %0d %0d",
                 i, out_valid, sat_flag, Va, Vb, Vc, e_ov, e_sat, e_a, e_b, e_c);
      end
`ifdef SCE_RECOMP_SATCNT_EN
      n_tests++;
      if (int'(sat_cnt) != e_cnt) begin n_fail++; $display("FAIL random_cnt[%0d]: got %0d expected %0d", i, sat_cnt, e_cnt); end
`endif
    end
  endtask

  task automatic test_reset_midflight();
    cycle(1, 1, 100, 200, 300);
    cycle(1, 0, 150, 250, 350);
    @(negedge clk); rst = 0; in_valid = 0; hist_clr = 0;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk); rst = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      n_tests++;
      if ({out_valid, sat_flag, Va, Vb, Vc} !== 44'd0) begin
        n_fail++;
        $display("FAIL reset_midflight[%0d]: got ov=%0b sat=%0b Va=%0d expected 0", i, out_valid, sat_flag, Va);
      end
    end
    // first sample after reset must only load history
    cycle(1, 0, 1, 2, 3);
    cycle(0, 0, 0, 0, 0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got ov=%0b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_seq("zero", 100, 0, 0, 100, 0, 0, 100, 100, 100);
    test_seq("pos", 0, 1000, 0, 0, 500, 0, 500, 500, -1000);
    test_seq("neg", 0, 0, 1000, 0, 0, 500, 500, -1000, 500);
    test_saturation();
    test_hist_clr();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
